// File: rtl/fifo_drain_to_ocm_pkg.sv
// Shared types for the HPS->FPGA FIFO drain engine: FSM states, FIFO CSR map, helpers.
package fifo_drain_to_ocm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_PWAIT,
        ST_BACKOFF,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } drain_state_e;

    // Word offsets of the Altera on-chip FIFO CSR slave
    typedef enum logic [2:0] {
        CSR_FILL_LEVEL = 3'd0,
        CSR_I_STATUS   = 3'd1
    } fifo_csr_e;

    // Unsigned 32-bit minimum, used to cap a burst to the words still owed
    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_drain_to_ocm.sv
// Drains the HPS->FPGA FIFO into on-chip memory s1: polls fill level, pops at most
// the observed fill, writes words to a wrapping OCM pointer, reports progress/done.
import fifo_drain_to_ocm_pkg::*;

module fifo_drain_to_ocm #(
    parameter int DW            = 32,
    parameter int OCM_AW        = 8,
    parameter int POLL_GAP      = 16,
    parameter int FILL_CSR_ADDR = int'(CSR_FILL_LEVEL)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       xfer_len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       words_done,
    output logic [OCM_AW-1:0] ocm_ptr,
    output logic [2:0]        csr_address,
    output logic              csr_read,
    input  logic [31:0]       csr_readdata,
    output logic              fifo_read,
    input  logic [DW-1:0]     fifo_readdata,
    input  logic              fifo_waitrequest,
    output logic [OCM_AW-1:0] ocm_address,
    output logic              ocm_clken,
    output logic              ocm_chipselect,
    output logic              ocm_write,
    output logic [DW-1:0]     ocm_writedata,
    output logic [DW/8-1:0]   ocm_byteenable
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    drain_state_e     state;
    logic [31:0]      len;
    logic [31:0]      avail;
    logic [GAP_W-1:0] gap_cnt;

    // Fixed Avalon sideband: always address the fill register, full-word OCM writes
    assign csr_address    = 3'(FILL_CSR_ADDR);
    assign ocm_clken      = 1'b1;
    assign ocm_byteenable = '1;

    // Transfer FSM; every Avalon strobe is a register set on entry to its state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            len            <= '0;
            avail          <= '0;
            gap_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_done     <= '0;
            ocm_ptr        <= '0;
            csr_read       <= 1'b0;
            fifo_read      <= 1'b0;
            ocm_address    <= '0;
            ocm_chipselect <= 1'b0;
            ocm_write      <= 1'b0;
            ocm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (xfer_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len        <= xfer_len;
                            words_done <= '0;
                            ocm_ptr    <= '0;
                            busy       <= 1'b1;
                            csr_read   <= 1'b1;
                            state      <= ST_POLL;
                        end
                    end
                end
                ST_POLL: begin
                    csr_read <= 1'b0;
                    state    <= ST_PWAIT;
                end
                ST_PWAIT: begin
                    // readdata is valid exactly one cycle after the read strobe
                    if (csr_readdata == '0) begin
                        gap_cnt <= '0;
                        state   <= ST_BACKOFF;
                    end else begin
                        avail     <= min_u32(csr_readdata, len - words_done);
                        fifo_read <= 1'b1;
                        state     <= ST_RD;
                    end
                end
                ST_BACKOFF: begin
                    if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        csr_read <= 1'b1;
                        state    <= ST_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_RD: begin
                    if (!fifo_waitrequest) begin
                        fifo_read <= 1'b0;
                        state     <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    ocm_writedata  <= fifo_readdata;
                    ocm_address    <= ocm_ptr;
                    ocm_write      <= 1'b1;
                    ocm_chipselect <= 1'b1;
                    state          <= ST_WR;
                end
                ST_WR: begin
                    ocm_write      <= 1'b0;
                    ocm_chipselect <= 1'b0;
                    ocm_ptr        <= ocm_ptr + 1'b1;  // natural wrap: OCM is a ring
                    words_done     <= words_done + 32'd1;
                    avail          <= avail - 32'd1;
                    if (words_done + 32'd1 == len) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (avail == 32'd1) begin
                        csr_read <= 1'b1;
                        state    <= ST_POLL;
                    end else begin
                        fifo_read <= 1'b1;
                        state     <= ST_RD;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_to_ocm.sv
// Randomized bench: FIFO/CSR/OCM behavioural models plus a per-transfer scoreboard.
module tb_fifo_drain_to_ocm;

    localparam int DW       = 32;
    localparam int OCM_AW   = 8;
    localparam int POLL_GAP = 16;
    localparam int LIM      = 20000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       xfer_len = '0;
    logic              busy, done;
    logic [31:0]       words_done;
    logic [OCM_AW-1:0] ocm_ptr;
    logic [2:0]        csr_address;
    logic              csr_read;
    logic [31:0]       csr_readdata = '0;
    logic              fifo_read;
    logic [DW-1:0]     fifo_readdata = '0;
    logic              fifo_waitrequest = 1'b0;
    logic [OCM_AW-1:0] ocm_address;
    logic              ocm_clken, ocm_chipselect, ocm_write;
    logic [DW-1:0]     ocm_writedata;
    logic [DW/8-1:0]   ocm_byteenable;

    fifo_drain_to_ocm #(.DW(DW), .OCM_AW(OCM_AW), .POLL_GAP(POLL_GAP), .FILL_CSR_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .xfer_len(xfer_len),
        .busy(busy), .done(done), .words_done(words_done), .ocm_ptr(ocm_ptr),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .fifo_read(fifo_read), .fifo_readdata(fifo_readdata), .fifo_waitrequest(fifo_waitrequest),
        .ocm_address(ocm_address), .ocm_clken(ocm_clken), .ocm_chipselect(ocm_chipselect),
        .ocm_write(ocm_write), .ocm_writedata(ocm_writedata), .ocm_byteenable(ocm_byteenable)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0]  fq[$];          // words currently held by the FIFO
    int unsigned  fill_script[$]; // forced fill replies, used before falling back to true size
    logic [31:0]  exp_q[$];       // words the transfer must land in OCM, in order
    int           addr_log[$];
    logic [31:0]  data_log[$];
    int           csr_log[$];
    logic [31:0]  mem [256];
    int wr_mode = 0;  // 0: never wait, 1: random wait, 2: 5 wait cycles per read
    int cyc = 0, wait_cnt = 0, pops = 0, pops_since = 0, done_cnt = 0, act_cnt = 0;
    int unsigned last_fill = 0;
    int viol_empty = 0, viol_fill = 0, viol_stab = 0, viol_cs = 0, viol_wr = 0;
    bit prev_rw = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Avalon slave models; everything they see holds through the next rising edge
    always @(negedge clk) begin
        if (!reset_n) begin
            wait_cnt = 0;
            prev_rw  = 1'b0;
        end else begin
            logic w;
            int unsigned f;
            cyc++;
            case (wr_mode)
                1:       w = ($urandom_range(0, 1) == 1);
                2:       w = (wait_cnt < 5);
                default: w = 1'b0;
            endcase
            fifo_waitrequest = w;
            if (prev_rw && !fifo_read) viol_stab++;
            if (fifo_read && ocm_write) viol_wr++;
            prev_rw = fifo_read && w;
            if (fifo_read && w) wait_cnt++;
            if (fifo_read && !w) begin
                wait_cnt = 0;
                pops++;
                pops_since++;
                if (pops_since > int'(last_fill)) viol_fill++;
                if (fq.size() == 0) begin
                    viol_empty++;
                    fifo_readdata = 32'hDEAD_BEEF;
                end else begin
                    fifo_readdata = fq.pop_front();
                end
            end
            if (csr_read) begin
                if (fill_script.size() > 0) begin
                    f = fill_script.pop_front();
                    if (f > fq.size()) f = fq.size();
                end else begin
                    f = fq.size();
                end
                csr_readdata = f;
                last_fill    = f;
                pops_since   = 0;
                csr_log.push_back(cyc);
            end
            if (ocm_write) begin
                mem[ocm_address] = ocm_writedata;
                addr_log.push_back(int'(ocm_address));
                data_log.push_back(ocm_writedata);
            end
            if (ocm_chipselect != ocm_write) viol_cs++;
            if (done) done_cnt++;
            if (csr_read || fifo_read || ocm_write) act_cnt++;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_wdone"}, words_done, 32'd0);
        chk({tag, "_ptr"}, ocm_ptr, 8'd0);
        chk({tag, "_strobes"}, {csr_read, fifo_read, ocm_write, ocm_chipselect}, 4'b0000);
        chk({tag, "_addr"}, {csr_address, ocm_address}, 11'd0);
        chk({tag, "_wdata"}, ocm_writedata, 32'd0);
        chk({tag, "_clken_be"}, {ocm_clken, ocm_byteenable}, 5'b11111);
    endtask

    // One full transfer: load FIFO model, start, wait for done, score against exp_q
    task automatic run_xfer(input string tag, input int len, input int extra,
                            input bit fixed_data, input int mid_start);
        int n, errs;
        fq.delete(); exp_q.delete(); addr_log.delete(); data_log.delete(); csr_log.delete();
        for (int i = 0; i < len + extra; i++) begin
            logic [31:0] d;
            d = fixed_data ? 32'hA0 + 32'(i) : $urandom;
            fq.push_back(d);
            if (i < len) exp_q.push_back(d);
        end
        done_cnt = 0; pops = 0;
        viol_empty = 0; viol_fill = 0; viol_stab = 0; viol_cs = 0; viol_wr = 0;
        @(negedge clk); start = 1'b1; xfer_len = 32'(len);
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1'b1);
        n = 0;
        while (done_cnt == 0 && n < LIM) begin
            @(negedge clk);
            n++;
            if (n == mid_start) begin start = 1'b1; xfer_len = 32'd99; end
            else start = 1'b0;
        end
        chk({tag, "_timeout"}, n >= LIM, 1'b0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_wdone"}, words_done, 32'(len));
        chk({tag, "_ptr"}, ocm_ptr, 8'(len % 256));
        chk({tag, "_busy_off"}, busy, 1'b0);
        chk({tag, "_pops"}, pops, len);
        chk({tag, "_nwr"}, addr_log.size(), len);
        errs = 0;
        for (int i = 0; i < len; i++)
            if (i >= addr_log.size() || addr_log[i] != i % 256 || data_log[i] !== exp_q[i]) errs++;
        chk({tag, "_order"}, errs, 0);
        chk({tag, "_viol"}, {8'(viol_empty), 8'(viol_fill), 8'(viol_stab), 8'(viol_cs), 8'(viol_wr)}, 40'd0);
        fq.delete(); fill_script.delete();
    endtask

    initial begin
        int n, act0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #1;
        check_reset_vals("rst0");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // reset asserted while a read is stalled by waitrequest
        wr_mode = 2;
        for (int i = 0; i < 20; i++) fq.push_back($urandom);
        done_cnt = 0;
        @(negedge clk); start = 1'b1; xfer_len = 32'd20;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!fifo_read && n < 200) begin @(negedge clk); n++; end
        chk("rst_reach_rd", fifo_read, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fq.delete();
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_cnt, 0);

        // basic four-word transfer with fixed pattern
        wr_mode = 0;
        run_xfer("basic", 4, 0, 1'b1, 0);
        chk("basic_mem0", mem[0], 32'hA0);
        chk("basic_mem3", mem[3], 32'hA3);

        // empty FIFO twice -> two full back-off periods
        fill_script = '{0, 0};
        run_xfer("backoff", 3, 0, 1'b0, 0);
        chk("backoff_npoll", csr_log.size() >= 3, 1'b1);
        if (csr_log.size() >= 3) begin
            chk("backoff_gap1", csr_log[1] - csr_log[0], POLL_GAP + 2);
            chk("backoff_gap2", csr_log[2] - csr_log[1], POLL_GAP + 2);
        end

        // long waitrequest stalls
        wr_mode = 2;
        run_xfer("wait", 5, 0, 1'b0, 0);

        // OCM pointer wrap
        wr_mode = 0;
        run_xfer("wrap", 300, 0, 1'b0, 0);
        chk("wrap_mem0", mem[0], exp_q[256]);
        chk("wrap_mem43", mem[43], exp_q[299]);
        chk("wrap_mem44", mem[44], exp_q[44]);

        // split fill, start pulsed while busy must be ignored
        fill_script = '{6, 4};
        run_xfer("split", 10, 0, 1'b0, 10);
        act0 = act_cnt;
        repeat (30) @(negedge clk);
        chk("split_quiet", act_cnt - act0, 0);

        // zero-length start
        done_cnt = 0;
        act0 = act_cnt;
        @(negedge clk); start = 1'b1; xfer_len = 32'd0;
        @(negedge clk); start = 1'b0;
        chk("zl_done", done, 1'b1);
        repeat (3) @(negedge clk);
        chk("zl_done_cnt", done_cnt, 1);
        chk("zl_quiet", act_cnt - act0, 0);
        chk("zl_busy", busy, 1'b0);

        // randomized transfers: random waitrequest, partial fills, surplus FIFO words
        wr_mode = 1;
        for (int k = 0; k < 6; k++) begin
            int ns;
            ns = $urandom_range(0, 3);
            for (int j = 0; j < ns; j++) fill_script.push_back($urandom_range(0, 4));
            run_xfer($sformatf("rnd%0d", k), $urandom_range(1, 40), $urandom_range(0, 5), 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
